// File: rtl/img_col_feeder_if.sv
// rtl/img_col_feeder_if.sv - K_H-port pixel read bus between the column feeder and image memory
// Ports:
//   mem_rd_en    read strobe shared by all K_H ports (master -> slave)
//   mem_rd_addr  K_H row-major pixel addresses (master -> slave)
//   mem_rd_data  K_H pixels, valid one cycle after mem_rd_en (slave -> master)
interface img_col_feeder_if #(
   parameter int K_H    = 3,
   parameter int ADDR_W = 16
);
   logic                           mem_rd_en;
   logic [K_H-1:0][ADDR_W-1:0]     mem_rd_addr;
   logic [K_H-1:0][7:0]            mem_rd_data;

   modport master (
      output mem_rd_en,
      output mem_rd_addr,
      input  mem_rd_data
   );

   modport slave (
      input  mem_rd_en,
      input  mem_rd_addr,
      output mem_rd_data
   );
endinterface

// File: rtl/img_col_feeder.sv
// rtl/img_col_feeder.sv - scans an image band by band and feeds K_H-pixel columns to a window register
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               one-cycle pulse starting a scan (ignored while busy)
//   stall               holds issue of new pixel reads
//   mem                 K_H-port read bus (master side)
//   col_data            column vector for the window register, index i = row r+i
//   load_en, clear      window-register shift strobe and clear
//   win_valid           window register holds a complete window at (win_row, win_col)
//   busy, done          scan in progress / one-cycle completion pulse
module img_col_feeder #(
   parameter int K_H    = 3,
   parameter int K_W    = 3,
   parameter int IMG_H  = 8,
   parameter int IMG_W  = 8,
   parameter int ADDR_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 stall,
   img_col_feeder_if.master     mem,
   output logic [K_H-1:0][7:0]  col_data,
   output logic                 load_en,
   output logic                 clear,
   output logic                 win_valid,
   output logic [ADDR_W-1:0]    win_row,
   output logic [ADDR_W-1:0]    win_col,
   output logic                 busy,
   output logic                 done
);

   localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(IMG_W - 1);
   localparam logic [ADDR_W-1:0] LAST_R = ADDR_W'(IMG_H - K_H);
   localparam logic [ADDR_W-1:0] KW_M1  = ADDR_W'(K_W - 1);
   localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);

   typedef enum logic [2:0] {IDLE, CLR, FETCH, DRAIN, DONE} state_t;

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   r, c;
   logic [ADDR_W-1:0]   row_base;      // r*IMG_W, kept incrementally to avoid a multiplier
   logic                rd;
   logic                ld_en;
   logic [ADDR_W-1:0]   ld_row, ld_col;
   logic                win_hit;

   // Column loaded this cycle completes a window once K_W columns are in.
   assign win_hit = ld_en && (ld_col >= KW_M1);

   always_comb begin
      state_nx = state;
      rd       = 1'b0;
      clear    = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE:  if (start) state_nx = CLR;
         CLR: begin
            clear    = 1'b1;
            state_nx = FETCH;
         end
         FETCH: if (!stall) begin
            rd = 1'b1;
            if (c == LAST_C) state_nx = DRAIN;
         end
         DRAIN: state_nx = (r < LAST_R) ? CLR : DONE;
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      mem.mem_rd_en   = rd;
      mem.mem_rd_addr = '0;
      if (rd) begin
         for (int i = 0; i < K_H; i++)
            mem.mem_rd_addr[i] = row_base + c + ADDR_W'(i * IMG_W);
      end
   end

   // Memory data arrives exactly one cycle after the read, aligned with load_en.
   assign load_en  = ld_en;
   assign col_data = ld_en ? mem.mem_rd_data : '0;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         r         <= '0;
         c         <= '0;
         row_base  <= '0;
         ld_en     <= 1'b0;
         ld_row    <= '0;
         ld_col    <= '0;
         win_valid <= 1'b0;
         win_row   <= '0;
         win_col   <= '0;
      end else begin
         state     <= state_nx;
         ld_en     <= rd;
         win_valid <= win_hit;
         if (win_hit) begin
            win_row <= ld_row;
            win_col <= ld_col - KW_M1;
         end
         if (rd) begin
            ld_row <= r;
            ld_col <= c;
            if (c != LAST_C) c <= c + 1'b1;
         end
         case (state)
            IDLE: if (start) begin
               r        <= '0;
               row_base <= '0;
            end
            CLR:  c <= '0;
            DRAIN: if (r < LAST_R) begin
               r        <= r + 1'b1;
               row_base <= row_base + W_A;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_img_col_feeder.sv
// tb/tb_img_col_feeder.sv - directed self-checking bench for img_col_feeder
module tb_img_col_feeder;

   localparam int AW = 16;

   logic clk = 1'b0;
   logic rst_n, start, stall, start3, stall3;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // 4x5 image, 3x3 window
   img_col_feeder_if #(.K_H(3), .ADDR_W(AW)) mif ();
   logic [2:0][7:0] col_data;
   logic            load_en, clear, win_valid, busy, done;
   logic [AW-1:0]   win_row, win_col;

   img_col_feeder #(.K_H(3), .K_W(3), .IMG_H(4), .IMG_W(5), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .mem(mif.master),
      .col_data(col_data), .load_en(load_en), .clear(clear), .win_valid(win_valid),
      .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
   );

   // 3x3 image, 3x3 window
   img_col_feeder_if #(.K_H(3), .ADDR_W(AW)) mif3 ();
   logic [2:0][7:0] col_data3;
   logic            load_en3, clear3, win_valid3, busy3, done3;
   logic [AW-1:0]   win_row3, win_col3;

   img_col_feeder #(.K_H(3), .K_W(3), .IMG_H(3), .IMG_W(3), .ADDR_W(AW)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .stall(stall3), .mem(mif3.master),
      .col_data(col_data3), .load_en(load_en3), .clear(clear3), .win_valid(win_valid3),
      .win_row(win_row3), .win_col(win_col3), .busy(busy3), .done(done3)
   );

   // Image memory: pixel value = address
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         mif.mem_rd_data[i]  <= mif.mem_rd_en  ? mif.mem_rd_addr[i][7:0]  : 8'hEE;
         mif3.mem_rd_data[i] <= mif3.mem_rd_en ? mif3.mem_rd_addr[i][7:0] : 8'hEE;
      end
   end

   int errors = 0;
   int checks = 0;

   // Monitor state
   int              win_q[$];
   int              clr_cnt = 0, done_cnt = 0, overlap_cnt = 0;
   logic [2:0][7:0] cap_col = '0;
   logic            prev_rd = 1'b0;
   logic [AW-1:0]   prev_a0 = '0;
   int              win3_cnt = 0, win3_code = -1;

   always @(negedge clk) begin
      #1;
      if (win_valid) win_q.push_back(int'(win_row) * 100 + int'(win_col));
      if (clear) clr_cnt++;
      if (clear && load_en) overlap_cnt++;
      if (clear3 && load_en3) overlap_cnt++;
      if (done) done_cnt++;
      if (load_en && prev_rd && prev_a0 == 16'd9) cap_col = col_data;
      prev_rd = mif.mem_rd_en;
      prev_a0 = mif.mem_rd_addr[0];
      if (win_valid3) begin
         win3_cnt++;
         win3_code = int'(win_row3) * 100 + int'(win_col3);
      end
   end

   int exp_win[6] = '{0, 1, 2, 100, 101, 102};

   function automatic bit windows_match();
      if (win_q.size() != 6) return 1'b0;
      foreach (exp_win[k]) if (win_q[k] != exp_win[k]) return 1'b0;
      return 1'b1;
   endfunction

   // Caller is at a negedge; returns at the negedge one cycle after done.
   task automatic run_scan(output int lat);
      int s;
      lat = -1;
      win_q.delete();
      clr_cnt = 0;
      cap_col = '0;
      start = 1'b1;
      s = cyc;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 200 && lat < 0; i++) begin
         @(negedge clk);
         if (done === 1'b1) lat = cyc - s;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      checks++;
      if ({busy, done, clear, load_en, win_valid, mif.mem_rd_en} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b, want 000000",
                  {busy, done, clear, load_en, win_valid, mif.mem_rd_en});
      end
      checks++;
      if (mif.mem_rd_addr !== '0 || col_data !== '0) begin
         errors++;
         $display("FAIL reset_data: addr=%h col=%h, want 0", mif.mem_rd_addr, col_data);
      end
      checks++;
      if (win_row !== '0 || win_col !== '0) begin
         errors++;
         $display("FAIL reset_win: row=%0d col=%0d, want 0", win_row, win_col);
      end
   endtask

   task automatic test_basic();
      int lat;
      int d0;
      d0 = done_cnt;
      run_scan(lat);
      checks++;
      if (lat !== 15) begin
         errors++;
         $display("FAIL basic_latency: got %0d, want 15", lat);
      end
      checks++;
      if (!windows_match()) begin
         errors++;
         $display("FAIL basic_windows: got %0d windows %p, want (0,0)(0,1)(0,2)(1,0)(1,1)(1,2)",
                  win_q.size(), win_q);
      end
      checks++;
      if (cap_col !== {8'd19, 8'd14, 8'd9}) begin
         errors++;
         $display("FAIL basic_col_r1c4: got %h, want 130e09", cap_col);
      end
      checks++;
      if (clr_cnt !== 2) begin
         errors++;
         $display("FAIL basic_clear_count: got %0d, want 2", clr_cnt);
      end
      checks++;
      if (done_cnt - d0 !== 1) begin
         errors++;
         $display("FAIL basic_done_count: got %0d, want 1", done_cnt - d0);
      end
   endtask

   task automatic test_stall();
      int lat;
      fork
         run_scan(lat);
         begin
            // start cycle s, CLR s+1, FETCH s+2, second FETCH s+3
            repeat (3) @(negedge clk);
            stall = 1'b1;
            for (int k = 0; k < 3; k++) begin
               #1;
               checks++;
               if (mif.mem_rd_en !== 1'b0) begin
                  errors++;
                  $display("FAIL stall_rd_en cycle %0d: got %b, want 0", k, mif.mem_rd_en);
               end
               @(negedge clk);
            end
            stall = 1'b0;
         end
      join
      checks++;
      if (lat !== 18) begin
         errors++;
         $display("FAIL stall_latency: got %0d, want 18", lat);
      end
      checks++;
      if (!windows_match()) begin
         errors++;
         $display("FAIL stall_windows: got %0d windows %p", win_q.size(), win_q);
      end
   endtask

   task automatic test_back_to_back();
      int lat1, lat2;
      int d0;
      d0 = done_cnt;
      fork
         run_scan(lat1);
         begin
            repeat (4) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      checks++;
      if (lat1 !== 15 || !windows_match()) begin
         errors++;
         $display("FAIL busy_start_scan: latency %0d windows %0d, want 15 and 6", lat1, win_q.size());
      end
      run_scan(lat2);
      checks++;
      if (lat2 !== 15 || !windows_match() || cap_col !== {8'd19, 8'd14, 8'd9}) begin
         errors++;
         $display("FAIL rerun_scan: latency %0d windows %0d col %h, want 15 6 130e09",
                  lat2, win_q.size(), cap_col);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (done_cnt - d0 !== 2) begin
         errors++;
         $display("FAIL back_to_back_done_count: got %0d, want 2", done_cnt - d0);
      end
   endtask

   task automatic test_reset_mid_scan();
      int lat;
      int d0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);     // cycle s+10: band 1, second FETCH
      checks++;
      if (mif.mem_rd_en !== 1'b1 || mif.mem_rd_addr[0] !== 16'd6) begin
         errors++;
         $display("FAIL mid_scan_fetch: rd_en=%b addr0=%0d, want 1 and 6",
                  mif.mem_rd_en, mif.mem_rd_addr[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, clear, load_en, win_valid, mif.mem_rd_en} !== 6'b0 ||
          mif.mem_rd_addr !== '0 || col_data !== '0) begin
         errors++;
         $display("FAIL async_reset: ctrl=%b addr=%h col=%h, want 0",
                  {busy, done, clear, load_en, win_valid, mif.mem_rd_en}, mif.mem_rd_addr, col_data);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      d0 = done_cnt;
      repeat (30) @(negedge clk);
      checks++;
      if (done_cnt !== d0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL aborted_scan: done pulses %0d busy %b, want 0 and 0", done_cnt - d0, busy);
      end
      run_scan(lat);
      checks++;
      if (lat !== 15 || !windows_match() || clr_cnt !== 2) begin
         errors++;
         $display("FAIL post_reset_scan: latency %0d windows %0d clears %0d, want 15 6 2",
                  lat, win_q.size(), clr_cnt);
      end
   endtask

   task automatic test_single_window();
      int lat, s;
      lat = -1;
      win3_cnt = 0;
      win3_code = -1;
      start3 = 1'b1;
      s = cyc;
      @(negedge clk);
      start3 = 1'b0;
      for (int i = 0; i < 50 && lat < 0; i++) begin
         @(negedge clk);
         if (done3 === 1'b1) lat = cyc - s;
      end
      @(negedge clk);
      checks++;
      if (lat !== 6) begin
         errors++;
         $display("FAIL single_latency: got %0d, want 6", lat);
      end
      checks++;
      if (win3_cnt !== 1 || win3_code !== 0) begin
         errors++;
         $display("FAIL single_window: got %0d windows last=%0d, want 1 at (0,0)", win3_cnt, win3_code);
      end
   endtask

   task automatic test_no_overlap();
      checks++;
      if (overlap_cnt !== 0) begin
         errors++;
         $display("FAIL clear_load_overlap: got %0d cycles, want 0", overlap_cnt);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      stall  = 1'b0;
      start3 = 1'b0;
      stall3 = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      test_basic();
      test_stall();
      test_back_to_back();
      test_reset_mid_scan();
      test_single_window();
      test_no_overlap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
